// File: rtl/flex_counter_core.sv
// flex_counter_core: parameterizable up-counter with a programmable rollover
// value and a registered rollover flag.
//
// Counting runs from 0 up to rollover_val, then wraps to 1. The rollover
// value is unsigned, and the counter also wraps naturally modulo
// 2^NUM_CNT_BITS.
//
// Optional macro FLEX_COUNTER_WRAP_ZERO_EN makes the counter wrap to 0
// instead of 1, so one period becomes rollover_val+1 counts.
//
// Priority at each rising edge: clear > count_enable > hold.
//
// Both outputs come straight from flops, so there is no combinational path
// from any input to an output.
module flex_counter_core #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

`ifdef FLEX_COUNTER_WRAP_ZERO_EN
  localparam logic [NUM_CNT_BITS-1:0] WRAP_VAL = '0;
`else
  localparam logic [NUM_CNT_BITS-1:0] WRAP_VAL = CNT_ONE;
`endif

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_flag;

  // Next-state selection: clear, then terminal-count wrap or increment, else hold
  always_comb begin
    next_count = count_out;
    if (clear) begin
      next_count = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        next_count = WRAP_VAL;
      end else begin
        next_count = count_out + CNT_ONE;
      end
    end
  end

  // The flag looks ahead at the next count, so it is high exactly while
  // count_out equals rollover_val. Clear forces it low even when
  // rollover_val is 0.
  always_comb begin
    next_flag = 1'b0;
    if (!clear) begin
      next_flag = (next_count == rollover_val);
    end
  end

  // Count and flag registers, asynchronously cleared by n_rst
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end

endmodule

// File: tb/tb_flex_counter_core.sv
// Testbench for flex_counter_core (NUM_CNT_BITS = 4).
module tb_flex_counter_core;

  localparam int W = 4;
`ifdef FLEX_COUNTER_WRAP_ZERO_EN
  localparam int WRAP = 0;
`else
  localparam int WRAP = 1;
`endif

  logic         tb_clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic         count_enable;
  logic [W-1:0] rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag;

  int vectors     = 0;
  int miscompares = 0;

  // Expected {rollover_flag, count_out} per edge
  logic [W:0] exp_q[$];

  // Reference model state
  int   m_cnt  = 0;
  logic m_flag = 1'b0;

  flex_counter_core #(.NUM_CNT_BITS(W)) dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  // Clock
  always #5 tb_clk = ~tb_clk;

  // Drives one cycle, predicts the result, pushes it, then waits to #1 after the edge
  task automatic drive(input logic c, input logic en, input int rv);
    clear        = c;
    count_enable = en;
    rollover_val = rv[W-1:0];
    if (!n_rst) begin
      m_cnt  = 0;
      m_flag = 1'b0;
    end else if (c) begin
      m_cnt  = 0;
      m_flag = 1'b0;
    end else begin
      if (en) begin
        if (m_cnt == rv) m_cnt = WRAP;
        else             m_cnt = (m_cnt + 1) % (1 << W);
      end
      m_flag = (m_cnt == rv);
    end
    exp_q.push_back({m_flag, m_cnt[W-1:0]});
    @(posedge tb_clk);
    #1;
  endtask

  // Applies n identical cycles and checks each against the scoreboard
  task automatic run_cycles(input string name, input int n, input logic c,
                            input logic en, input int rv);
    logic [W:0] exp;
    for (int i = 0; i < n; i++) begin
      drive(c, en, rv);
      exp = exp_q.pop_front();
      vectors++;
      if ({rollover_flag, count_out} !== exp) begin
        miscompares++;
        $display("FAIL %s cyc%0d: got flag=%b cnt=%0d, expected flag=%b cnt=%0d",
                 name, i, rollover_flag, count_out, exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    run_cycles("reset_idle", 2, 1'b0, 1'b0, 8);
    vectors++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_const: got cnt=%0d flag=%b, expected 0/0", count_out, rollover_flag);
    end
    run_cycles("reset_over_enable", 2, 1'b0, 1'b1, 8);
    vectors++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_over_enable_const: got cnt=%0d flag=%b, expected 0/0", count_out, rollover_flag);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_clear();
    run_cycles("clear_pre", 3, 1'b0, 1'b1, 8);
    run_cycles("clear_over_enable", 2, 1'b1, 1'b1, 8);
    vectors++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_const: got cnt=%0d flag=%b, expected 0/0", count_out, rollover_flag);
    end
  endtask

  task automatic test_count_rollover();
    run_cycles("rollover8_clr", 1, 1'b1, 1'b0, 8);
    run_cycles("rollover8", 4, 1'b0, 1'b1, 8);
    vectors++;
    if (count_out !== 4'd4 || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL rollover8_at4: got cnt=%0d flag=%b, expected 4/0", count_out, rollover_flag);
    end
    run_cycles("rollover8", 4, 1'b0, 1'b1, 8);
    vectors++;
    if (count_out !== 4'd8 || rollover_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL rollover8_at8: got cnt=%0d flag=%b, expected 8/1", count_out, rollover_flag);
    end
    run_cycles("rollover8", 1, 1'b0, 1'b1, 8);
    vectors++;
    if (count_out !== W'(WRAP) || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL rollover8_at9: got cnt=%0d flag=%b, expected %0d/0", count_out, rollover_flag, WRAP);
    end
    run_cycles("rollover8_more", 12, 1'b0, 1'b1, 8);
  endtask

  task automatic test_full_scale();
    run_cycles("full_clr", 1, 1'b1, 1'b0, 15);
    run_cycles("full", 15, 1'b0, 1'b1, 15);
    vectors++;
    if (count_out !== 4'd15 || rollover_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL full_at15: got cnt=%0d flag=%b, expected 15/1", count_out, rollover_flag);
    end
    run_cycles("full", 1, 1'b0, 1'b1, 15);
    vectors++;
    if (count_out !== W'(WRAP) || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL full_at16: got cnt=%0d flag=%b, expected %0d/0", count_out, rollover_flag, WRAP);
    end
  endtask

  task automatic test_small_rollover();
    run_cycles("rv1_clr", 1, 1'b1, 1'b0, 1);
    run_cycles("rv1", 6, 1'b0, 1'b1, 1);
    run_cycles("rv0_clr", 1, 1'b1, 1'b0, 0);
    run_cycles("rv0", 20, 1'b0, 1'b1, 0);
  endtask

  task automatic test_enable_gating();
    run_cycles("gate_clr", 1, 1'b1, 1'b0, 4);
    run_cycles("gate_en", 3, 1'b0, 1'b1, 4);
    run_cycles("gate_hold", 2, 1'b0, 1'b0, 4);
    vectors++;
    if (count_out !== 4'd3 || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL gate_hold3: got cnt=%0d flag=%b, expected 3/0", count_out, rollover_flag);
    end
    run_cycles("gate_en", 1, 1'b0, 1'b1, 4);
    run_cycles("gate_flag_hold", 3, 1'b0, 1'b0, 4);
    vectors++;
    if (count_out !== 4'd4 || rollover_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL gate_flag_hold: got cnt=%0d flag=%b, expected 4/1", count_out, rollover_flag);
    end
  endtask

  task automatic test_rv_change();
    run_cycles("rvchg_clr", 1, 1'b1, 1'b0, 10);
    run_cycles("rvchg_pre", 6, 1'b0, 1'b1, 10);
    run_cycles("rvchg_post", 16, 1'b0, 1'b1, 3);
  endtask

  task automatic test_async_reset();
    run_cycles("async_pre", 5, 1'b0, 1'b1, 12);
    @(negedge tb_clk);
    n_rst = 1'b0;
    #1;
    vectors++;
    if (count_out !== 4'd0 || rollover_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got cnt=%0d flag=%b, expected 0/0", count_out, rollover_flag);
    end
    m_cnt  = 0;
    m_flag = 1'b0;
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;
    run_cycles("async_post", 4, 1'b0, 1'b1, 12);
  endtask

  task automatic test_random();
    int rv;
    logic c, en;
    rv = 5;
    for (int i = 0; i < 300; i++) begin
      c  = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ((c || en) && $urandom_range(0, 15) == 0) rv = $urandom_range(0, 15);
      run_cycles("random", 1, c, en, rv);
    end
  endtask

  initial begin
    n_rst        = 1'b0;
    clear        = 1'b0;
    count_enable = 1'b0;
    rollover_val = 4'd8;
    #1;
    test_reset();
    test_clear();
    test_count_rollover();
    test_full_scale();
    test_small_rollover();
    test_enable_gating();
    test_rv_change();
    test_async_reset();
    test_random();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flex_counter_core.md
Name: flex_counter_core

Overview:
- Parameterizable synchronous up-counter with a programmable rollover value and a registered rollover flag.
- Generic timing/sequencing primitive used by the USB/Ethernet bridge for bit, byte and packet counters.
- Counts from 0 up to rollover_val, then wraps to 1.
- Supports synchronous clear and count-enable gating.

Parameters:
- NUM_CNT_BITS, 4, width of count_out and rollover_val; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear; highest priority after reset.
- count_enable  input  1  increment qualifier.
- rollover_val  input  NUM_CNT_BITS  terminal count value, unsigned.
- count_out  output  NUM_CNT_BITS  current count, registered.
- rollover_flag  output  1  high while count_out equals rollover_val; registered.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, n_rst).

Behaviour:
- Reset (n_rst=0, asynchronous):
  - count_out=0, rollover_flag=0 immediately.
  - Held while n_rst is low, regardless of clear or count_enable.
  - Reset mid-count discards the count.
- Next-state priority at each rising clk edge: clear > count_enable > hold.
- clear=1:
  - count_out<=0, rollover_flag<=0.
  - Applies even if count_enable=1.
- count_enable=1, clear=0:
  - If count_out==rollover_val, count_out<=1.
  - Otherwise count_out<=count_out+1, modulo 2^NUM_CNT_BITS.
- count_enable=0, clear=0: count_out and rollover_flag hold.
- rollover_flag:
  - Registered from the next-state value: rollover_flag<=(next_count==rollover_val).
  - It is therefore high in exactly the cycles where count_out==rollover_val.
  - Zero combinational path from inputs to outputs.
- Sequence from reset with rollover_val=8 and enable held: 0,1,...,7,8(flag=1),1,2,...
  - Flag is high for one cycle per period of 8 counts.
- rollover_val=2^N-1 (e.g. 15 for N=4): counts 1..15; flag at 15; wraps to 1.
- rollover_val=1: count_out alternates 0→1, then stays 1 with flag=1 every cycle while enabled.
- rollover_val=0:
  - No special case; counter increments through natural wrap 2^N-1→0.
  - Flag asserts when count_out=0 is reached via counting.
  - Next enabled cycle goes to 1.
- rollover_val changed mid-count:
  - Takes effect for the next comparison.
  - If the new value is below count_out, the counter continues upward, wraps modulo 2^N, and later matches.
- Enable deasserted in the flag cycle: flag stays high while held.

Optional Feature:
- Macro FLEX_COUNTER_WRAP_ZERO_EN.
- Defined: on rollover (count_out==rollover_val and enabled), count_out<=0 instead of 1.
  - Period becomes rollover_val+1 counts.
  - Flag rule unchanged (high while count_out==rollover_val).
- Undefined (default): wrap to 1 as specified above.

Test Plan:
- Reset with idle inputs: n_rst=0 for 2 clocks, rollover_val=8 -> count_out=0, rollover_flag=0.
- Reset overrides enable: n_rst=0, count_enable=1 for 2 clocks -> count_out=0, flag=0.
- Clear over enable: clear=1, count_enable=1, rollover_val=8 for 2 clocks -> count_out=0, flag=0.
- Count and rollover, rollover_val=8, enable held after reset:
  - After 4 edges: count_out=4, flag=0.
  - After 8 edges: count_out=8, flag=1.
  - After 9 edges: count_out=1, flag=0.
- Full-scale rollover: rollover_val=15, enable for 15 edges -> count_out=15, flag=1; 16th edge -> 1, flag=0.
- Enable gating: rollover_val=4, enable for 3 edges, then count_enable=0 for 2 edges -> count_out=3 held, flag=0.
